// File: rtl/memory_cycle.sv
// Memory stage of a 5-stage pipeline: word-addressed data memory, the M->W
// pipeline register and the writeback result mux.
module memory_cycle #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RD_M,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  output logic [31:0] ResultW,
  output logic [4:0]  RD_W,
  output logic        RegWriteW,
  output logic [31:0] ReadDataM,
  output logic        MisalignErr
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] word_addr;
  logic          misaligned;
  logic          store_ok;
  logic          load_misaligned;

  logic [31:0] alu_result_w;
  logic [31:0] read_data_w;
  logic [31:0] pc_plus4_w;
  logic [1:0]  result_src_w;

  // Upper address bits are dropped, so accesses wrap modulo the memory size.
  assign word_addr       = ALUResultM[AW+1:2];
  assign misaligned      = (ALUResultM[1:0] != 2'b00);
  assign store_ok        = MemWriteM && !misaligned;
  assign load_misaligned = RegWriteM && (ResultSrcM == 2'b01) && misaligned;
  assign ReadDataM       = mem[word_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= 32'h0000_0000;
      end
    end else if (store_ok) begin
      mem[word_addr] <= WriteDataM;
    end
  end

  // Sticky error: only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      MisalignErr <= 1'b0;
    end else if ((MemWriteM && misaligned) || load_misaligned) begin
      MisalignErr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_w <= 32'h0000_0000;
      read_data_w  <= 32'h0000_0000;
      pc_plus4_w   <= 32'h0000_0000;
      result_src_w <= 2'b00;
      RD_W         <= 5'd0;
      RegWriteW    <= 1'b0;
    end else begin
      alu_result_w <= ALUResultM;
      read_data_w  <= ReadDataM;
      pc_plus4_w   <= PCPlus4M;
      result_src_w <= ResultSrcM;
      RD_W         <= RD_M;
      RegWriteW    <= RegWriteM;
    end
  end

  always_comb begin
    ResultW = 32'h0000_0000;
    case (result_src_w)
      2'b00:   ResultW = alu_result_w;
      2'b01:   ResultW = read_data_w;
      2'b10:   ResultW = pc_plus4_w;
      default: ResultW = 32'h0000_0000;
    endcase
  end

endmodule
